// File: rtl/mm_stream_host.sv
// Host-side AXI-Stream endpoint for the mm accelerator: streams buffered A/B operands out, captures results; tvalid one cycle after start.
// Honours m_axis_tready stalls; s_axis_tready high throughout RECV, or on alternate cycles when MM_STREAM_HOST_RX_THROTTLE_EN is defined.
module mm_stream_host #(
  parameter int M        = 4,
  parameter int D_W      = 8,
  parameter int D_W_ACC  = 16,
  localparam int TX_WORDS = 2 * M * M * D_W / 32,
  localparam int RX_WORDS = M * M * D_W_ACC / 32,
  localparam int TXW      = $clog2(TX_WORDS),
  localparam int RXW      = $clog2(RX_WORDS)
) (
  input  logic            mm_clk,
  input  logic            mm_rst_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            err_tlast,
  output logic [31:0]     cycle_count,
  input  logic            load_wr_en,
  input  logic [TXW-1:0]  load_wr_addr,
  input  logic [31:0]     load_wr_data,
  input  logic [RXW-1:0]  res_rd_addr,
  output logic [31:0]     res_rd_data,
  output logic [31:0]     m_axis_tdata,
  output logic [3:0]      m_axis_tkeep,
  output logic            m_axis_tlast,
  output logic            m_axis_tvalid,
  input  logic            m_axis_tready,
  input  logic [31:0]     s_axis_tdata,
  input  logic [3:0]      s_axis_tkeep,
  input  logic            s_axis_tlast,
  input  logic            s_axis_tvalid,
  output logic            s_axis_tready
);

  localparam logic [TXW-1:0] TX_LAST = TXW'(TX_WORDS - 1);
  localparam logic [RXW-1:0] RX_LAST = RXW'(RX_WORDS - 1);

  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [TXW-1:0] tx_cnt;
  logic [RXW-1:0] rx_cnt;
  logic [31:0]    op_buf  [TX_WORDS];
  logic [31:0]    res_buf [RX_WORDS];

  logic idle_like;
  logic job_start;
  logic tx_fire;
  logic rx_fire;
  logic rx_final;
  logic rx_err;
  logic cnt_en;
  logic unused_tkeep;

  assign unused_tkeep = ^s_axis_tkeep;

  assign idle_like = (state == IDLE) || (state == DONE);
  assign job_start = start && idle_like;
  assign tx_fire   = m_axis_tvalid && m_axis_tready;
  assign rx_fire   = s_axis_tvalid && s_axis_tready;
  assign rx_final  = rx_fire && (s_axis_tlast || (rx_cnt == RX_LAST));
  assign rx_err    = rx_fire && (s_axis_tlast != (rx_cnt == RX_LAST));

  // The window opens on the edge that accepts the first operand beat.
  assign cnt_en = ((state == SEND) && ((tx_cnt != '0) || tx_fire)) || (state == RECV);

  assign busy          = (state == SEND) || (state == RECV);
  assign done          = (state == DONE);
  assign m_axis_tvalid = (state == SEND);
  assign m_axis_tdata  = (state == SEND) ? op_buf[tx_cnt] : '0;
  assign m_axis_tkeep  = (state == SEND) ? 4'hF : 4'h0;
  assign m_axis_tlast  = (state == SEND) && (tx_cnt == TX_LAST);
  assign res_rd_data   = res_buf[res_rd_addr];

`ifdef MM_STREAM_HOST_RX_THROTTLE_EN
  logic rx_toggle;

  always_ff @(posedge mm_clk or negedge mm_rst_n) begin
    if (!mm_rst_n) begin
      rx_toggle <= 1'b1;
    end else if (state != RECV) begin
      rx_toggle <= 1'b1;
    end else begin
      rx_toggle <= ~rx_toggle;
    end
  end

  assign s_axis_tready = (state == RECV) && rx_toggle;
`else
  assign s_axis_tready = (state == RECV);
`endif

  always_ff @(posedge mm_clk or negedge mm_rst_n) begin
    if (!mm_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = SEND;
      SEND:       if (tx_fire && (tx_cnt == TX_LAST)) state_nxt = RECV;
      RECV:       if (rx_final) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mm_clk or negedge mm_rst_n) begin
    if (!mm_rst_n) begin
      tx_cnt      <= '0;
      rx_cnt      <= '0;
      err_tlast   <= 1'b0;
      cycle_count <= '0;
    end else begin
      if (job_start) begin
        tx_cnt      <= '0;
        rx_cnt      <= '0;
        err_tlast   <= 1'b0;
        cycle_count <= '0;
      end else begin
        if (tx_fire) tx_cnt <= tx_cnt + 1'b1;
        if (rx_fire) rx_cnt <= rx_cnt + 1'b1;
        if (rx_err) err_tlast <= 1'b1;
        if (cnt_en && (cycle_count != 32'hFFFF_FFFF)) cycle_count <= cycle_count + 32'd1;
      end
    end
  end

  // Buffers hold their contents across reset; writes are gated by FSM state.
  always_ff @(posedge mm_clk) begin
    if (load_wr_en && idle_like) op_buf[load_wr_addr] <= load_wr_data;
    if (rx_fire) res_buf[rx_cnt] <= s_axis_tdata;
  end

endmodule

// File: tb/tb_mm_stream_host.sv
// Directed bench for mm_stream_host; covers the throttled result path when MM_STREAM_HOST_RX_THROTTLE_EN is defined.
module tb_mm_stream_host;

  localparam int M = 4;
  localparam int D_W = 8;
  localparam int D_W_ACC = 16;
`ifdef MM_STREAM_HOST_RX_THROTTLE_EN
  localparam int RX_CYC = 15;
`else
  localparam int RX_CYC = 8;
`endif

  logic        mm_clk;
  logic        mm_rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic        err_tlast;
  logic [31:0] cycle_count;
  logic        load_wr_en;
  logic [2:0]  load_wr_addr;
  logic [31:0] load_wr_data;
  logic [2:0]  res_rd_addr;
  logic [31:0] res_rd_data;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tkeep;
  logic        s_axis_tlast;
  logic        s_axis_tvalid;
  logic        s_axis_tready;

  int vectors = 0;
  int miscompares = 0;

  mm_stream_host #(.M(M), .D_W(D_W), .D_W_ACC(D_W_ACC)) dut (
    .mm_clk(mm_clk), .mm_rst_n(mm_rst_n), .start(start), .busy(busy), .done(done),
    .err_tlast(err_tlast), .cycle_count(cycle_count),
    .load_wr_en(load_wr_en), .load_wr_addr(load_wr_addr), .load_wr_data(load_wr_data),
    .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready)
  );

  initial mm_clk = 1'b0;
  always #5 mm_clk = ~mm_clk;

  function automatic logic [31:0] op_word(input int i);
    return {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)};
  endfunction

  task automatic tick();
    @(posedge mm_clk);
    #1;
  endtask

  task automatic start_job_send();
    int n;
    m_axis_tready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (m_axis_tvalid && n < 40) begin
      tick();
      n++;
    end
    vectors++;
    if (n != 8) begin
      miscompares++;
      $display("FAIL send_len: got %0d beats, want 8", n);
    end
  endtask

  task automatic drive_rx(input logic [31:0] base, input int first, input int n, input int last_at);
    int w;
    for (int i = 0; i < n; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = base + 32'(first + i);
      s_axis_tlast  = (first + i == last_at);
      w = 0;
      while (!s_axis_tready && w < 8) begin
        tick();
        w++;
      end
      if (w == 8) begin
        vectors++;
        miscompares++;
        $display("FAIL rx_ready_timeout: beat %0d never accepted, want tready=1", first + i);
      end
      tick();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic test_reset();
    mm_rst_n = 1'b0;
    start = 0; load_wr_en = 0; load_wr_addr = 0; load_wr_data = 0; res_rd_addr = 0;
    m_axis_tready = 0; s_axis_tdata = 0; s_axis_tkeep = 4'hF; s_axis_tlast = 0; s_axis_tvalid = 0;
    #2;
    vectors++;
    if ({busy, done, err_tlast, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, s_axis_tready} !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b, want 0", {busy, done, err_tlast, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, s_axis_tready});
    end
    vectors++;
    if (m_axis_tdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_tdata: got %h, want 0", m_axis_tdata);
    end
    vectors++;
    if (cycle_count !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_cycle_count: got %0d, want 0", cycle_count);
    end
    repeat (2) tick();
    mm_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_send();
    for (int i = 0; i < 8; i++) begin
      load_wr_en = 1'b1;
      load_wr_addr = 3'(i);
      load_wr_data = op_word(i);
      tick();
    end
    load_wr_en = 1'b0;
    m_axis_tready = 1'b1;
    start = 1'b1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_before_start: got %b, want 0", busy);
    end
    tick();
    start = 1'b0;
    for (int b = 0; b < 8; b++) begin
      vectors++;
      if ({m_axis_tvalid, busy, m_axis_tkeep, m_axis_tlast, m_axis_tdata} !== {1'b1, 1'b1, 4'hF, b == 7, op_word(b)}) begin
        miscompares++;
        $display("FAIL tx_beat%0d: got v=%b busy=%b keep=%h last=%b data=%h, want v=1 busy=1 keep=f last=%b data=%h",
                 b, m_axis_tvalid, busy, m_axis_tkeep, m_axis_tlast, m_axis_tdata, b == 7, op_word(b));
      end
      tick();
    end
    vectors++;
    if ({m_axis_tvalid, busy, s_axis_tready} !== 3'b011) begin
      miscompares++;
      $display("FAIL enter_recv: got tvalid/busy/tready=%b, want 011", {m_axis_tvalid, busy, s_axis_tready});
    end
  endtask

  task automatic test_recv();
    drive_rx(32'hA000_0000, 0, 8, 7);
    vectors++;
    if ({done, busy, err_tlast, s_axis_tready} !== 4'b1000) begin
      miscompares++;
      $display("FAIL recv_status: got done/busy/err/tready=%b, want 1000", {done, busy, err_tlast, s_axis_tready});
    end
    vectors++;
    if (cycle_count !== 32'(8 + RX_CYC)) begin
      miscompares++;
      $display("FAIL cycle_count_nostall: got %0d, want %0d", cycle_count, 8 + RX_CYC);
    end
    for (int i = 0; i < 8; i++) begin
      res_rd_addr = 3'(i);
      #1;
      vectors++;
      if (res_rd_data !== 32'hA000_0000 + 32'(i)) begin
        miscompares++;
        $display("FAIL res_word%0d: got %h, want %h", i, res_rd_data, 32'hA000_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_send_stall();
    int b;
    int c;
    start = 1'b1;
    tick();
    start = 1'b0;
    b = 0;
    c = 0;
    while (b < 8 && c < 40) begin
      m_axis_tready = (c % 2 == 0);
      vectors++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, b == 7, op_word(b)}) begin
        miscompares++;
        $display("FAIL stall_beat%0d_c%0d: got v=%b last=%b data=%h, want v=1 last=%b data=%h",
                 b, c, m_axis_tvalid, m_axis_tlast, m_axis_tdata, b == 7, op_word(b));
      end
      if (m_axis_tready) b++;
      tick();
      c++;
    end
    vectors++;
    if (m_axis_tvalid !== 1'b0 || c != 15) begin
      miscompares++;
      $display("FAIL stall_end: got tvalid=%b cycles=%0d, want tvalid=0 cycles=15", m_axis_tvalid, c);
    end
    drive_rx(32'hA000_0000, 0, 8, 7);
    vectors++;
    if (cycle_count !== 32'(15 + RX_CYC)) begin
      miscompares++;
      $display("FAIL cycle_count_stall: got %0d, want %0d", cycle_count, 15 + RX_CYC);
    end
  endtask

  task automatic test_early_tlast();
    start_job_send();
    drive_rx(32'hC000_0000, 0, 6, 5);
    vectors++;
    if ({done, busy, err_tlast} !== 3'b101) begin
      miscompares++;
      $display("FAIL early_tlast_status: got done/busy/err=%b, want 101", {done, busy, err_tlast});
    end
    res_rd_addr = 3'd5;
    #1;
    vectors++;
    if (res_rd_data !== 32'hC000_0005) begin
      miscompares++;
      $display("FAIL early_tlast_word5: got %h, want c0000005", res_rd_data);
    end
    res_rd_addr = 3'd6;
    #1;
    vectors++;
    if (res_rd_data !== 32'hA000_0006) begin
      miscompares++;
      $display("FAIL early_tlast_word6: got %h, want a0000006", res_rd_data);
    end
  endtask

  task automatic test_missing_tlast();
    start_job_send();
    vectors++;
    if (err_tlast !== 1'b0) begin
      miscompares++;
      $display("FAIL err_cleared_on_start: got %b, want 0", err_tlast);
    end
    drive_rx(32'hD000_0000, 0, 7, -1);
    vectors++;
    if ({done, busy, err_tlast} !== 3'b010) begin
      miscompares++;
      $display("FAIL missing_tlast_mid: got done/busy/err=%b, want 010", {done, busy, err_tlast});
    end
    drive_rx(32'hD000_0000, 7, 1, -1);
    vectors++;
    if ({done, busy, err_tlast} !== 3'b101) begin
      miscompares++;
      $display("FAIL missing_tlast_end: got done/busy/err=%b, want 101", {done, busy, err_tlast});
    end
    res_rd_addr = 3'd7;
    #1;
    vectors++;
    if (res_rd_data !== 32'hD000_0007) begin
      miscompares++;
      $display("FAIL missing_tlast_word7: got %h, want d0000007", res_rd_data);
    end
  endtask

  task automatic test_ignore_busy();
    int n;
    m_axis_tready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    m_axis_tready = 1'b0;
    start = 1'b1;
    load_wr_en = 1'b1;
    load_wr_addr = 3'd5;
    load_wr_data = 32'hDEAD_BEEF;
    tick();
    start = 1'b0;
    load_wr_en = 1'b0;
    vectors++;
    if ({busy, m_axis_tdata} !== {1'b1, op_word(2)}) begin
      miscompares++;
      $display("FAIL no_restart: got busy=%b data=%h, want busy=1 data=%h", busy, m_axis_tdata, op_word(2));
    end
    m_axis_tready = 1'b1;
    repeat (3) tick();
    vectors++;
    if (m_axis_tdata !== op_word(5)) begin
      miscompares++;
      $display("FAIL write_protect: got %h, want %h", m_axis_tdata, op_word(5));
    end
    n = 0;
    while (m_axis_tvalid && n < 20) begin
      tick();
      n++;
    end
    vectors++;
    if (n != 3) begin
      miscompares++;
      $display("FAIL ignore_busy_tail: got %0d remaining beats, want 3", n);
    end
  endtask

  task automatic test_reset_mid_recv();
    drive_rx(32'hE000_0000, 0, 3, -1);
    mm_rst_n = 1'b0;
    #1;
    vectors++;
    if ({m_axis_tvalid, s_axis_tready, busy, done, err_tlast} !== 5'b0 || cycle_count !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid_recv: got v/rdy/busy/done/err=%b count=%0d, want 00000 count=0",
               {m_axis_tvalid, s_axis_tready, busy, done, err_tlast}, cycle_count);
    end
    tick();
    mm_rst_n = 1'b1;
    tick();
    start_job_send();
    drive_rx(32'h5000_0000, 0, 8, 7);
    vectors++;
    if ({done, busy, err_tlast} !== 3'b100 || cycle_count !== 32'(8 + RX_CYC)) begin
      miscompares++;
      $display("FAIL clean_job_after_reset: got done/busy/err=%b count=%0d, want 100 count=%0d",
               {done, busy, err_tlast}, cycle_count, 8 + RX_CYC);
    end
    res_rd_addr = 3'd0;
    #1;
    vectors++;
    if (res_rd_data !== 32'h5000_0000) begin
      miscompares++;
      $display("FAIL clean_job_word0: got %h, want 50000000", res_rd_data);
    end
  endtask

`ifdef MM_STREAM_HOST_RX_THROTTLE_EN
  task automatic test_throttle();
    int captured;
    int cycles;
    start_job_send();
    s_axis_tvalid = 1'b1;
    captured = 0;
    cycles = 0;
    while (captured < 8 && cycles < 40) begin
      s_axis_tdata = 32'hF000_0000 + 32'(captured);
      s_axis_tlast = (captured == 7);
      vectors++;
      if (s_axis_tready !== (cycles % 2 == 0)) begin
        miscompares++;
        $display("FAIL throttle_ready_c%0d: got %b, want %b", cycles, s_axis_tready, cycles % 2 == 0);
      end
      if (s_axis_tready) captured++;
      tick();
      cycles++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    vectors++;
    if (cycles != 15 || done !== 1'b1 || err_tlast !== 1'b0) begin
      miscompares++;
      $display("FAIL throttle_span: got cycles=%0d done=%b err=%b, want 15 1 0", cycles, done, err_tlast);
    end
    res_rd_addr = 3'd7;
    #1;
    vectors++;
    if (res_rd_data !== 32'hF000_0007) begin
      miscompares++;
      $display("FAIL throttle_word7: got %h, want f0000007", res_rd_data);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_send();
    test_recv();
    test_send_stall();
    test_early_tlast();
    test_missing_tlast();
    test_ignore_busy();
    test_reset_mid_recv();
`ifdef MM_STREAM_HOST_RX_THROTTLE_EN
    test_throttle();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mm_stream_host.md
Name: mm_stream_host

Overview:
- Host-side stream endpoint for the matrix-multiply accelerator.
- Acts as the AXI-Stream master that feeds packed A and B operands into the accelerator's s2mm input.
- Acts as the AXI-Stream slave that drains the accelerator's mm2s result stream into a local result buffer.
- Stands in for the DMA in standalone benches and lets the system controller run self-contained jobs with a cycle-count readout.

Parameters:
- M, 4, matrix dimension (square M x M operands).
- D_W, 8, operand element width in bits; 32 must be divisible by D_W.
- D_W_ACC, 16, result element width in bits; 32 must be divisible by D_W_ACC.
- TX_WORDS, 2*M*M*D_W/32, derived: 32-bit words sent per job (A then B, row-major) = 8.
- RX_WORDS, M*M*D_W_ACC/32, derived: 32-bit words expected back per job = 8.

Ports:
- mm_clk  in  1  sole clock, rising edge.
- mm_rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle job start pulse.
- busy  out  1  high in SEND or RECV.
- done  out  1  sticky job-complete flag.
- err_tlast  out  1  sticky result-framing error.
- cycle_count  out  32  cycles from first TX beat to last RX beat.
- load_wr_en  in  1  operand buffer write strobe.
- load_wr_addr  in  $clog2(TX_WORDS)  operand buffer word address.
- load_wr_data  in  32  operand word.
- res_rd_addr  in  $clog2(RX_WORDS)  result buffer read address.
- res_rd_data  out  32  result word, combinational read.
- m_axis_tdata  out  32  operand stream data.
- m_axis_tkeep  out  4  operand stream byte enables.
- m_axis_tlast  out  1  operand stream last beat.
- m_axis_tvalid  out  1  operand stream valid.
- m_axis_tready  in  1  operand stream ready.
- s_axis_tdata  in  32  result stream data.
- s_axis_tkeep  in  4  result stream byte enables (ignored).
- s_axis_tlast  in  1  result stream last beat.
- s_axis_tvalid  in  1  result stream valid.
- s_axis_tready  out  1  result stream ready.

Behaviour:
- Reset: async on mm_rst_n low.
  - FSM goes to IDLE; tx_cnt=0, rx_cnt=0.
  - busy=0, done=0, err_tlast=0, cycle_count=0.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0; s_axis_tready=0.
  - Buffer contents are not reset.
- Reset asserted mid-job aborts the job immediately; no partial beat completes.
- FSM states: IDLE, SEND, RECV, DONE.
- IDLE/DONE:
  - load_wr_en writes load_wr_data to the operand buffer at the next edge.
  - start moves the FSM to SEND, clears done, err_tlast, cycle_count and both counters.
  - start and load_wr_en in the same cycle: the write occurs first and the job sends the new word.
- SEND:
  - m_axis_tvalid=1, m_axis_tdata=buf[tx_cnt], m_axis_tkeep=4'hF.
  - m_axis_tlast=1 when tx_cnt==TX_WORDS-1.
  - tdata and tlast stay stable while tvalid is high and tready is low (AXI rule).
  - On tvalid&tready: tx_cnt increments. On the last beat the FSM goes to RECV next cycle and tvalid drops.
  - Outputs are registered: tvalid rises the cycle after start is sampled.
- RECV:
  - s_axis_tready=1 (see Optional Feature).
  - On tvalid&tready: res_buf[rx_cnt] <= s_axis_tdata; rx_cnt increments.
  - Final beat condition: tlast==1 or rx_cnt==RX_WORDS-1.
  - tlast on a beat with rx_cnt<RX_WORDS-1: err_tlast=1 (early last).
  - No tlast on the beat with rx_cnt==RX_WORDS-1: err_tlast=1 (missing last).
  - On the final beat the FSM goes to DONE and done=1 in the next cycle.
- SEND/RECV:
  - start and load_wr_en are ignored; the buffer is write-protected while busy.
  - m_axis_tvalid=0 outside SEND; s_axis_tready=0 outside RECV.
- cycle_count:
  - Increments every cycle from the edge of the first accepted TX beat through the edge of the final RX beat inclusive.
  - Saturates at 32'hFFFFFFFF.
  - Holds in DONE until the next start.
- s_axis_tvalid outside RECV is ignored; no data is written.

Optional Feature:
- Macro: MM_STREAM_HOST_RX_THROTTLE_EN.
- Defined:
  - In RECV, s_axis_tready follows an internal toggle register that is reset to 1 on entry to RECV and inverts every cycle, giving ready high on alternate cycles. This exercises result-side backpressure.
  - The toggle is registered, not combinationally dependent on s_axis_tvalid.
- Undefined: s_axis_tready is constant 1 throughout RECV.

Test Plan:
- Load words 0x03020100..0x1F1E1D1C at addr 0..7, pulse start, hold m_axis_tready=1 -> 8 consecutive beats with matching data, tkeep=F, tlast only on beat 7, busy=1 from the cycle after start.
- Same job with m_axis_tready low on odd cycles -> tdata/tlast stable while stalled, 8 beats delivered in order, no duplicates.
- Return 8 result beats 0xA0000000+i, tlast on beat 7 -> res_rd_data(i) matches, done=1, err_tlast=0, cycle_count = cycles from first TX beat to last RX beat (16 with no stalls and no gap).
- Return tlast on beat 5 -> FSM reaches DONE after 6 beats, err_tlast=1; then return 8 beats with no tlast -> err_tlast=1 after beat 7.
- Pulse start and load_wr_en during SEND -> no restart, buffer unchanged; drop mm_rst_n mid-RECV -> tvalid/tready/busy/done=0 immediately, next start runs a clean job.
- With MM_STREAM_HOST_RX_THROTTLE_EN defined, hold s_axis_tvalid=1 for the whole RECV -> tready pattern 1,0,1,0..., exactly 8 words captured over 15 cycles.
